pwl_act_pipe: RTL

Parametrised, table-programmable piecewise-linear activation unit (tanh/sigmoid/etc.) for the fixed-point GAN datapath.
- Replaces fixed-constant PWL blocks: breakpoints, slopes and intercepts are loaded at runtime through a config port.
- Optional odd-symmetry mode halves table usage for tanh-like functions.
- 3-stage pipeline with valid/ready backpressure.
- Sits between accumulator output and the next layer's input buffer.

---
 rtl/pwl_act_pipe.sv | 102 ++++++++++
 1 files changed

// File: rtl/pwl_act_pipe.sv
// pwl_act_pipe: runtime-programmable piecewise-linear activation, 3-stage valid/ready pipeline
module pwl_act_pipe #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int NSEG   = 8,
    parameter int IDX_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] y_out,
    input  logic                     sym_mode,
    input  logic                     cfg_we,
    input  logic [1:0]               cfg_sel,
    input  logic [IDX_W-1:0]         cfg_idx,
    input  logic signed [DATA_W-1:0] cfg_data,
    output logic                     cfg_ready,
    output logic                     busy
);
    localparam int N = 2**IDX_W;
    localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
    logic signed [DATA_W-1:0] bp [N];
    logic signed [DATA_W-1:0] slope [N];
    logic signed [DATA_W-1:0] icpt [N];
    logic v1, v2, v3, free1, free2, free3, acc, cfg_ok;
    logic signed [DATA_W-1:0] xe, xe1, ic2, sat, res;
    logic [IDX_W-1:0] seg, seg1;
    logic neg1, neg2;
    logic signed [2*DATA_W-1:0] p2, s;

    assign free3     = ~v3 | out_ready;
    assign free2     = ~v2 | free3;
    assign free1     = ~v1 | free2;
    assign in_ready  = free1 & ~cfg_we;
    assign acc       = in_valid & in_ready;
    assign cfg_ready = ~(v1 | v2 | v3);
    assign busy      = ~cfg_ready;
    assign cfg_ok    = cfg_we & cfg_ready;
    assign out_valid = v3;

    // Segment index counts breakpoints at or below xe, so table order does not matter
    always_comb begin
        xe = (sym_mode & x_in[DATA_W-1]) ? ((x_in == SMIN) ? ~x_in : -x_in) : x_in;
        seg = '0;
        for (int k = 0; k < NSEG-1; k++)
            if (bp[k] <= xe) seg = seg + IDX_W'(1);
    end

    always_comb begin
        s = (p2 >>> FRAC_W) + (2*DATA_W)'(ic2);
        sat = (s[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){s[2*DATA_W-1]}})
            ? {s[2*DATA_W-1], {(DATA_W-1){~s[2*DATA_W-1]}}} : s[DATA_W-1:0];
        res = neg2 ? ((sat == SMIN) ? ~sat : -sat) : sat;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            y_out <= '0;
            xe1   <= '0;
            seg1  <= '0;
            neg1  <= 1'b0;
            p2    <= '0;
            ic2   <= '0;
            neg2  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                bp[i]    <= '0;
                slope[i] <= '0;
                icpt[i]  <= '0;
            end
        end else begin
            if (cfg_ok && cfg_sel == 2'd0 && int'(cfg_idx) < NSEG-1) bp[cfg_idx] <= cfg_data;
            if (cfg_ok && cfg_sel == 2'd1 && int'(cfg_idx) < NSEG) slope[cfg_idx] <= cfg_data;
            if (cfg_ok && cfg_sel == 2'd2 && int'(cfg_idx) < NSEG) icpt[cfg_idx] <= cfg_data;
            if (free1) begin
                v1 <= acc;
                if (acc) begin
                    xe1  <= xe;
                    seg1 <= seg;
                    neg1 <= sym_mode & x_in[DATA_W-1];
                end
            end
            if (free2) begin
                v2 <= v1;
                if (v1) begin
                    p2   <= (2*DATA_W)'(xe1) * (2*DATA_W)'(slope[seg1]);
                    ic2  <= icpt[seg1];
                    neg2 <= neg1;
                end
            end
            if (free3) begin
                v3 <= v2;
                if (v2) y_out <= res;
            end
        end
endmodule
